// File: rtl/vector_alu_scheduler.sv
// =============================================================================
// Module      : vector_alu_scheduler
// Description : Round-robin scheduler sharing one single-cycle vector ALU among
//               NUM_REQ requesters, with S1 issue and S2 response stages.
//               Optional macro VECTOR_ALU_SCHED_STATS_EN enables a transfer counter.
// Revision    : 1.0 - initial release
// =============================================================================
`default_nettype none

module vector_alu_scheduler #(
    parameter int NUM_REQ   = 4,
    parameter int OP_WIDTH  = 6,
    parameter int VEC_WIDTH = 512,
    parameter int ID_WIDTH  = $clog2(NUM_REQ)
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [NUM_REQ-1:0]             req_valid_i,
    output logic [NUM_REQ-1:0]             req_ready_o,
    input  logic [NUM_REQ*OP_WIDTH-1:0]    req_op_i,
    input  logic [NUM_REQ*VEC_WIDTH-1:0]   req_op1_i,
    input  logic [NUM_REQ*VEC_WIDTH-1:0]   req_op2_i,
    output logic [OP_WIDTH-1:0]            alu_operation_o,
    output logic [VEC_WIDTH-1:0]           alu_operand1_o,
    output logic [VEC_WIDTH-1:0]           alu_operand2_o,
    input  logic [VEC_WIDTH-1:0]           alu_result_i,
    output logic                           rsp_valid_o,
    output logic [ID_WIDTH-1:0]            rsp_id_o,
    output logic [VEC_WIDTH-1:0]           rsp_result_o,
    input  logic                           rsp_ready_i,
    output logic [31:0]                    busy_count_o
);

    localparam logic [ID_WIDTH-1:0] C_PTR_RESET = ID_WIDTH'(NUM_REQ - 1);

    logic [ID_WIDTH-1:0]  r_ptr;
    logic                 r_s1_valid;
    logic [ID_WIDTH-1:0]  r_s1_id;

    logic                 w_adv1;
    logic                 w_adv2;
    logic                 w_xfer;
    logic                 w_gnt_any;
    logic [NUM_REQ-1:0]   w_gnt_onehot;
    logic [ID_WIDTH-1:0]  w_gnt_idx;
    logic [ID_WIDTH-1:0]  w_idx;
    logic [OP_WIDTH-1:0]  w_sel_op;
    logic [VEC_WIDTH-1:0] w_sel_op1;
    logic [VEC_WIDTH-1:0] w_sel_op2;

    assign w_adv2 = !rsp_valid_o || rsp_ready_i;
    assign w_adv1 = !r_s1_valid || w_adv2;

    // Round-robin search starting one past the last granted requester
    always_comb begin
        w_gnt_onehot = '0;
        w_gnt_idx    = '0;
        w_gnt_any    = 1'b0;
        w_idx        = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            w_idx = ID_WIDTH'((int'(r_ptr) + i) % NUM_REQ);
            if (!w_gnt_any && req_valid_i[w_idx]) begin
                w_gnt_any           = 1'b1;
                w_gnt_idx           = w_idx;
                w_gnt_onehot[w_idx] = 1'b1;
            end
        end
    end

    always_comb begin
        w_sel_op  = '0;
        w_sel_op1 = '0;
        w_sel_op2 = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (w_gnt_onehot[k]) begin
                w_sel_op  = req_op_i[k*OP_WIDTH +: OP_WIDTH];
                w_sel_op1 = req_op1_i[k*VEC_WIDTH +: VEC_WIDTH];
                w_sel_op2 = req_op2_i[k*VEC_WIDTH +: VEC_WIDTH];
            end
        end
    end

    // No request is accepted while reset is held
    assign w_xfer      = w_adv1 && w_gnt_any && !reset;
    assign req_ready_o = w_xfer ? w_gnt_onehot : '0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_s1_valid      <= 1'b0;
            r_s1_id         <= '0;
            r_ptr           <= C_PTR_RESET;
            alu_operation_o <= '0;
            alu_operand1_o  <= '0;
            alu_operand2_o  <= '0;
        end else if (w_adv1) begin
            r_s1_valid <= w_xfer;
            if (w_xfer) begin
                r_s1_id         <= w_gnt_idx;
                r_ptr           <= w_gnt_idx;
                alu_operation_o <= w_sel_op;
                alu_operand1_o  <= w_sel_op1;
                alu_operand2_o  <= w_sel_op2;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rsp_valid_o  <= 1'b0;
            rsp_id_o     <= '0;
            rsp_result_o <= '0;
        end else if (w_adv2) begin
            rsp_valid_o <= r_s1_valid;
            if (r_s1_valid) begin
                rsp_id_o     <= r_s1_id;
                rsp_result_o <= alu_result_i;
            end
        end
    end

`ifdef VECTOR_ALU_SCHED_STATS_EN
    logic [31:0] r_busy_count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_busy_count <= '0;
        end else if (w_xfer) begin
            r_busy_count <= r_busy_count + 32'd1;
        end
    end

    assign busy_count_o = r_busy_count;
`else
    assign busy_count_o = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_vector_alu_scheduler.sv
// =============================================================================
// Module      : tb_vector_alu_scheduler
// Description : Directed, table-driven bench for vector_alu_scheduler; ALU is
//               stubbed as operand1 ^ operand2.
// Revision    : 1.0 - initial release
// =============================================================================
`default_nettype none

module tb_vector_alu_scheduler;

    localparam int NUM_REQ = 4;
    localparam int OPW     = 6;
    localparam int VW      = 512;
    localparam int IDW     = 2;

    logic                    clk = 1'b0;
    logic                    reset;
    logic [NUM_REQ-1:0]      req_valid_i;
    logic [NUM_REQ-1:0]      req_ready_o;
    logic [NUM_REQ*OPW-1:0]  req_op_i;
    logic [NUM_REQ*VW-1:0]   req_op1_i;
    logic [NUM_REQ*VW-1:0]   req_op2_i;
    logic [OPW-1:0]          alu_operation_o;
    logic [VW-1:0]           alu_operand1_o;
    logic [VW-1:0]           alu_operand2_o;
    logic [VW-1:0]           alu_result_i;
    logic                    rsp_valid_o;
    logic [IDW-1:0]          rsp_id_o;
    logic [VW-1:0]           rsp_result_o;
    logic                    rsp_ready_i;
    logic [31:0]             busy_count_o;

    int checks = 0;
    int errors = 0;

    logic [OPW-1:0] op_k  [NUM_REQ];
    logic [VW-1:0]  op1_k [NUM_REQ];
    logic [VW-1:0]  op2_k [NUM_REQ];
    logic [VW-1:0]  exp_res [NUM_REQ];

    typedef struct {
        logic [NUM_REQ-1:0] valid;
        logic               rrdy;
        logic [NUM_REQ-1:0] exp_ready;
        logic               exp_rvalid;
        logic [IDW-1:0]     exp_rid;
    } vec_t;

    vec_t tbl [21];

    vector_alu_scheduler #(
        .NUM_REQ  (NUM_REQ),
        .OP_WIDTH (OPW),
        .VEC_WIDTH(VW),
        .ID_WIDTH (IDW)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .req_valid_i    (req_valid_i),
        .req_ready_o    (req_ready_o),
        .req_op_i       (req_op_i),
        .req_op1_i      (req_op1_i),
        .req_op2_i      (req_op2_i),
        .alu_operation_o(alu_operation_o),
        .alu_operand1_o (alu_operand1_o),
        .alu_operand2_o (alu_operand2_o),
        .alu_result_i   (alu_result_i),
        .rsp_valid_o    (rsp_valid_o),
        .rsp_id_o       (rsp_id_o),
        .rsp_result_o   (rsp_result_o),
        .rsp_ready_i    (rsp_ready_i),
        .busy_count_o   (busy_count_o)
    );

    assign alu_result_i = alu_operand1_o ^ alu_operand2_o;

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [VW-1:0] act, input logic [VW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_data();
        for (int k = 0; k < NUM_REQ; k++) begin
            req_op_i[k*OPW +: OPW]  = op_k[k];
            req_op1_i[k*VW +: VW]   = op1_k[k];
            req_op2_i[k*VW +: VW]   = op2_k[k];
        end
    endtask

    task automatic set_row(input int i, input logic [3:0] v, input logic r,
                           input logic [3:0] er, input logic ev, input logic [1:0] eid);
        tbl[i].valid      = v;
        tbl[i].rrdy       = r;
        tbl[i].exp_ready  = er;
        tbl[i].exp_rvalid = ev;
        tbl[i].exp_rid    = eid;
    endtask

    initial begin
        // Requester data; requester 2 carries the single-request pattern
        for (int k = 0; k < NUM_REQ; k++) begin
            op_k[k]  = OPW'(6'h10 + k);
            op1_k[k] = {16{32'hA5A5_0000 | 32'(k)}};
            op2_k[k] = {16{32'h0000_1234 << (4 * k)}};
        end
        op_k[2]  = 6'h05;
        op1_k[2] = {VW{1'b1}};
        op2_k[2] = {64{8'h0F}};
        for (int k = 0; k < NUM_REQ; k++) exp_res[k] = op1_k[k] ^ op2_k[k];

        // Contention, rr wrap, backpressure, drain, bubble collapse
        set_row( 0, 4'b1111, 1'b1, 4'b0001, 1'b0, 2'd0);
        set_row( 1, 4'b1111, 1'b1, 4'b0010, 1'b0, 2'd0);
        set_row( 2, 4'b1111, 1'b1, 4'b0100, 1'b1, 2'd0);
        set_row( 3, 4'b1111, 1'b1, 4'b1000, 1'b1, 2'd1);
        set_row( 4, 4'b1111, 1'b1, 4'b0001, 1'b1, 2'd2);
        set_row( 5, 4'b1111, 1'b1, 4'b0010, 1'b1, 2'd3);
        set_row( 6, 4'b1111, 1'b0, 4'b0000, 1'b1, 2'd0);
        set_row( 7, 4'b1111, 1'b0, 4'b0000, 1'b1, 2'd0);
        set_row( 8, 4'b1111, 1'b0, 4'b0000, 1'b1, 2'd0);
        set_row( 9, 4'b1111, 1'b1, 4'b0100, 1'b1, 2'd0);
        set_row(10, 4'b0000, 1'b1, 4'b0000, 1'b1, 2'd1);
        set_row(11, 4'b0000, 1'b1, 4'b0000, 1'b1, 2'd2);
        set_row(12, 4'b0000, 1'b1, 4'b0000, 1'b0, 2'd0);
        set_row(13, 4'b0001, 1'b0, 4'b0001, 1'b0, 2'd0);
        set_row(14, 4'b0010, 1'b0, 4'b0010, 1'b0, 2'd0);
        set_row(15, 4'b0000, 1'b1, 4'b0000, 1'b1, 2'd0);
        set_row(16, 4'b0100, 1'b0, 4'b0100, 1'b1, 2'd1);
        set_row(17, 4'b0000, 1'b0, 4'b0000, 1'b1, 2'd1);
        set_row(18, 4'b0000, 1'b1, 4'b0000, 1'b1, 2'd1);
        set_row(19, 4'b0000, 1'b1, 4'b0000, 1'b1, 2'd2);
        set_row(20, 4'b0000, 1'b1, 4'b0000, 1'b0, 2'd0);

        // Reset with random inputs
        reset       = 1'b1;
        req_valid_i = NUM_REQ'($urandom);
        rsp_ready_i = 1'($urandom);
        for (int w = 0; w < NUM_REQ * VW / 32; w++) begin
            req_op1_i[w*32 +: 32] = $urandom;
            req_op2_i[w*32 +: 32] = $urandom;
        end
        req_op_i = 24'($urandom);
        tick();
        tick();
        #3;
        chk("rst_ready",  VW'(req_ready_o), '0);
        chk("rst_aluop",  VW'(alu_operation_o), '0);
        chk("rst_alu1",   alu_operand1_o, '0);
        chk("rst_alu2",   alu_operand2_o, '0);
        chk("rst_rvalid", VW'(rsp_valid_o), '0);
        chk("rst_rid",    VW'(rsp_id_o), '0);
        chk("rst_rres",   rsp_result_o, '0);
        chk("rst_busy",   VW'(busy_count_o), '0);
        tick();
        reset = 1'b0;
        load_data();

        for (int i = 0; i < 21; i++) begin
            req_valid_i = tbl[i].valid;
            rsp_ready_i = tbl[i].rrdy;
            #3;
            chk($sformatf("tbl%0d_ready", i), VW'(req_ready_o), VW'(tbl[i].exp_ready));
            chk($sformatf("tbl%0d_rvalid", i), VW'(rsp_valid_o), VW'(tbl[i].exp_rvalid));
            if (tbl[i].exp_rvalid) begin
                chk($sformatf("tbl%0d_rid", i), VW'(rsp_id_o), VW'(tbl[i].exp_rid));
                chk($sformatf("tbl%0d_rres", i), rsp_result_o, exp_res[tbl[i].exp_rid]);
            end
            tick();
        end

        // Single request from requester 2
        req_valid_i = 4'b0100;
        rsp_ready_i = 1'b1;
        #3;
        chk("single_ready", VW'(req_ready_o), VW'(4'b0100));
        tick();
        req_valid_i = 4'b0000;
        #3;
        chk("single_aluop", VW'(alu_operation_o), VW'(6'h05));
        chk("single_alu1",  alu_operand1_o, {VW{1'b1}});
        chk("single_rv1",   VW'(rsp_valid_o), '0);
        tick();
        #3;
        chk("single_rvalid", VW'(rsp_valid_o), VW'(1'b1));
        chk("single_rid",    VW'(rsp_id_o), VW'(2'd2));
        chk("single_rres",   rsp_result_o, {64{8'hF0}});
        tick();

        // Fill S1 and S2, then reset mid-flight
        req_valid_i = 4'b1111;
        #3;
        chk("mf_ready_a", VW'(req_ready_o), VW'(4'b1000));
        tick();
        #3;
        chk("mf_ready_b", VW'(req_ready_o), VW'(4'b0001));
        tick();
        rsp_ready_i = 1'b0;
        req_valid_i = 4'b0000;
        #1;
        chk("mf_rv_before", VW'(rsp_valid_o), VW'(1'b1));
        reset = 1'b1;
        #1;
        chk("mf_rvalid", VW'(rsp_valid_o), '0);
        chk("mf_aluop",  VW'(alu_operation_o), '0);
        tick();
        reset       = 1'b0;
        rsp_ready_i = 1'b1;
        for (int c = 0; c < 3; c++) begin
            #3;
            chk($sformatf("mf_drop%0d", c), VW'(rsp_valid_o), '0);
            tick();
        end
        req_valid_i = 4'b1111;
        #3;
        chk("mf_grant0", VW'(req_ready_o), VW'(4'b0001));
        tick();

        // Stats: ten accepted operations after a fresh reset
        req_valid_i = 4'b0000;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        req_valid_i = 4'b1111;
        for (int c = 0; c < 10; c++) begin
            #3;
            chk($sformatf("st_ready%0d", c), VW'(req_ready_o), VW'(4'b0001 << (c % 4)));
            tick();
        end
        req_valid_i = 4'b0000;
        tick();
        tick();
        #3;
`ifdef VECTOR_ALU_SCHED_STATS_EN
        chk("st_busy", VW'(busy_count_o), VW'(32'd10));
`else
        chk("st_busy", VW'(busy_count_o), VW'(32'd0));
`endif
        chk("st_rvalid", VW'(rsp_valid_o), '0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
